// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_pkg
// Purpose  : Seven-segment glyph codes and scan-decoder state encoding.
// Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  // Active-low g..a patterns for hex digits 0..F
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    CAPTURED = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_to_num.sv
`default_nettype none
// ============================================================================
// Module   : seg_to_num
// Purpose  : Combinational active-low glyph to hex nibble lookup.
// Revision : 1.0  initial release
// ============================================================================
module seg_to_num
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    invalid_o = 1'b0;
    case (seg_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Rebuilds displayed hex digits from a multiplexed 7-seg bus and
//            publishes one consistent frame per complete scan sweep.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int SETTLE  = 4,      // must be >= 2
  parameter int TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  clr_err,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  frame_valid,
  output logic                  multi_err,
  output logic                  stale
);

  localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam int                TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(TIMEOUT);

  logic [7:0]          seg_q, seg_prev_q;
  logic [DIGITS-1:0]   an_q, an_prev_q;
  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] shadow_nib_q, shadow_nib_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   dp_q, err_q;
  logic                frame_valid_q, multi_err_q;
  logic [TO_W-1:0]     to_q, to_d;

  logic                onehot, multi_hot, changed, capture, publish;
  logic [DIGITS-1:0]   cap_mask;
  logic [3:0]          dec_nib;
  logic                dec_inv;

  assign onehot    = ($countones(~an_q) == 1);
  assign multi_hot = ($countones(~an_q) > 1);
  assign changed   = ({an_q, seg_q} != {an_prev_q, seg_prev_q});
  assign publish   = &seen_q;

  seg_to_num u_dec (
    .seg_i     (seg_q[6:0]),
    .nibble_o  (dec_nib),
    .invalid_o (dec_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (onehot) begin
          state_d = SETTLING;
          cnt_d   = '0;
        end
      end
      SETTLING: begin
        if (!onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == SETTLE_LAST) state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        // One capture per dwell: wait here until the bus moves on
        if (changed) begin
          state_d = onehot ? SETTLING : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    capture  = (state_q == SETTLING) && (state_d == CAPTURED);
    cap_mask = capture ? ~an_q : '0;
  end

  always_comb begin
    shadow_nib_d = shadow_nib_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_err_d = shadow_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        shadow_nib_d[4*i +: 4] = dec_nib;
        shadow_dp_d[i]         = ~seg_q[SEG_DP];
        shadow_err_d[i]        = dec_inv;
      end
    end
  end

  // A capture landing in the publish cycle belongs to the next frame
  assign seen_d = (publish ? '0 : seen_q) | cap_mask;
  assign to_d   = publish ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q         <= '1;
      an_q          <= '1;
      seg_prev_q    <= '1;
      an_prev_q     <= '1;
      seen_q        <= '0;
      shadow_nib_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_err_q  <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      multi_err_q   <= 1'b0;
      to_q          <= '0;
    end else begin
      seg_q         <= seg_in;
      an_q          <= an_in;
      seg_prev_q    <= seg_q;
      an_prev_q     <= an_q;
      seen_q        <= seen_d;
      shadow_nib_q  <= shadow_nib_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_err_q  <= shadow_err_d;
      frame_valid_q <= publish;
      multi_err_q   <= multi_hot | (multi_err_q & ~clr_err);
      to_q          <= to_d;
      if (publish) begin
        digits_q <= shadow_nib_q;
        dp_q     <= shadow_dp_q;
        err_q    <= shadow_err_q;
      end
    end
  end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign err_mask    = err_q;
  assign frame_valid = frame_valid_q;
  assign multi_err   = multi_err_q;
  assign stale       = (to_q == TO_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Directed scan sweeps checked against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int DIGITS  = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          seg_in = '1;
  logic [DIGITS-1:0]   an_in = '1;
  logic                clr_err = 1'b0;
  logic [4*DIGITS-1:0] digits_out;
  logic [DIGITS-1:0]   dp_out, err_mask;
  logic                frame_valid, multi_err, stale;

  logic [6:0] lut_seg = '0;
  logic [3:0] lut_nib;
  logic       lut_inv;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_count = 0;
  int last_fv_cyc = 0;
  int stale_rise = 0;
  logic prev_stale = 1'b0;
  logic stale_at_fv = 1'b0;

  logic [6:0] GLY [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .dp_out      (dp_out),
    .err_mask    (err_mask),
    .frame_valid (frame_valid),
    .multi_err   (multi_err),
    .stale       (stale),
    .clr_err     (clr_err)
  );

  seg_to_num u_ref_lut (
    .seg_i     (lut_seg),
    .nibble_o  (lut_nib),
    .invalid_o (lut_inv)
  );

  // {invalid, nibble} straight from the glyph table
  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    ref_decode = 5'b1_0000;
    for (int v = 0; v < 16; v++)
      if (GLY[v] == s) ref_decode = {1'b0, 4'(v)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A digit is captured when its sampled {an,seg} has been identical for
  // exactly SETTLE consecutive samples; a frame publishes one edge after
  // every digit has been captured since the previous publish.
  logic [DIGITS-1:0]   m_an = '1;
  logic [7:0]          m_seg = '1;
  int                  m_run = 0;
  int                  m_to = 0;
  logic [3:0]          m_nib [DIGITS];
  logic [DIGITS-1:0]   m_dp_sh = '0, m_err_sh = '0, m_seen = '0;
  logic [4*DIGITS-1:0] e_digits = '0;
  logic [DIGITS-1:0]   e_dp = '0, e_err = '0;
  logic                e_fv = 1'b0, e_multi = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   seen, dps, errs;
    logic [4*DIGITS-1:0] pack;
    logic [4:0]          dec;
    if (!rst_n) begin
      m_an <= '1; m_seg <= '1; m_run <= 0; m_to <= 0; m_seen <= '0;
      e_digits <= '0; e_dp <= '0; e_err <= '0; e_fv <= 1'b0; e_multi <= 1'b0;
    end else begin
      nib = m_nib; seen = m_seen; dps = m_dp_sh; errs = m_err_sh;
      pack = '0;
      for (int i = 0; i < DIGITS; i++) pack[4*i +: 4] = m_nib[i];
      if (&m_seen) begin
        e_fv <= 1'b1; e_digits <= pack; e_dp <= m_dp_sh; e_err <= m_err_sh;
        seen = '0;
        m_to <= 0;
      end else begin
        e_fv <= 1'b0;
        m_to <= (m_to < TIMEOUT) ? m_to + 1 : m_to;
      end
      if ($countones(~m_an) == 1 && m_run == SETTLE) begin
        dec = ref_decode(m_seg[6:0]);
        for (int i = 0; i < DIGITS; i++) begin
          if (!m_an[i]) begin
            nib[i] = dec[4] ? 4'h0 : dec[3:0];
            dps[i] = ~m_seg[7];
            errs[i] = dec[4];
            seen[i] = 1'b1;
          end
        end
      end
      e_multi <= ($countones(~m_an) >= 2) || (e_multi && !clr_err);
      m_run <= ({an_in, seg_in} == {m_an, m_seg}) ? m_run + 1 : 1;
      m_an <= an_in; m_seg <= seg_in;
      m_nib <= nib; m_seen <= seen; m_dp_sh <= dps; m_err_sh <= errs;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      check("digits_out",  64'(digits_out),  64'(e_digits));
      check("dp_out",      64'(dp_out),      64'(e_dp));
      check("err_mask",    64'(err_mask),    64'(e_err));
      check("frame_valid", 64'(frame_valid), 64'(e_fv));
      check("multi_err",   64'(multi_err),   64'(e_multi));
      check("stale",       64'(stale),       64'(m_to == TIMEOUT));
      if (frame_valid === 1'b1) begin
        fv_count++;
        last_fv_cyc = cyc;
        stale_at_fv = stale;
      end
      if (stale === 1'b1 && !prev_stale) stale_rise = cyc;
      prev_stale = stale;
    end
  end

  // ---------------- stimulus ----------------
  task automatic show_raw(input int d, input logic [7:0] seg, input int n);
    an_in  = ~(8'd1 << d);
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [3:0] v, input int n);
    show_raw(d, {1'b1, GLY[v]}, n);
  endtask

  task automatic blank(input int n);
    an_in  = '1;
    seg_in = '1;
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int f0;
    int n;
    logic [4:0] r;
    logic [3:0] part [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    int ord [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

    for (int p = 0; p < 128; p++) begin
      lut_seg = 7'(p);
      #1;
      r = ref_decode(lut_seg);
      check("lut_nibble",  64'(lut_nib), 64'(r[3:0]));
      check("lut_invalid", 64'(lut_inv), 64'(r[4]));
    end

    @(negedge clk); @(negedge clk); #2;
    check("rst_digits", 64'(digits_out), 64'h0);
    check("rst_flags",  64'({frame_valid, multi_err, stale, dp_out, err_mask}), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain sweep 1..8
    f0 = fv_count;
    for (int d = 0; d < 8; d++) show(d, 4'(d + 1), 10);
    blank(3); #2;
    check("t1_frames", 64'(fv_count - f0), 64'd1);
    check("t1_digits", 64'(digits_out), 64'h87654321);
    check("t1_err",    64'(err_mask), 64'h0);
    check("t1_dp",     64'(dp_out), 64'h0);

    // Reset after 5 digits, then a reordered sweep must need all 8
    for (int d = 0; d < 5; d++) show(d, 4'h9, 10);
    rst_n = 1'b0;
    repeat (2) @(negedge clk); #2;
    check("rst2_digits", 64'(digits_out), 64'h0);
    check("rst2_flags",  64'({frame_valid, multi_err, stale, dp_out, err_mask}), 64'h0);
    rst_n = 1'b1;
    blank(2);
    f0 = fv_count;
    for (int k = 0; k < 7; k++) show(ord[k], 4'(ord[k]), 10);
    #2;
    check("t6_no_early_frame", 64'(fv_count - f0), 64'd0);
    show(ord[7], 4'(ord[7]), 10);
    blank(3); #2;
    check("t6_frames", 64'(fv_count - f0), 64'd1);
    check("t6_digits", 64'(digits_out), 64'h76543210);

    // Short dwell on digit 3 leaves the frame incomplete
    f0 = fv_count;
    for (int d = 0; d < 8; d++) show(d, part[d], (d == 3) ? SETTLE - 1 : 10);
    blank(3); #2;
    check("t2_no_frame", 64'(fv_count - f0), 64'd0);
    for (int d = 0; d < 8; d++) show(d, 4'(d + 1), 10);
    blank(3); #2;
    check("t2_frames", 64'(fv_count - f0), 64'd1);
    check("t2_digits", 64'(digits_out), 64'h0FED4321);

    // Invalid glyph with dp lit on digit 2
    for (int d = 0; d < 8; d++) begin
      if (d == 2) show_raw(2, 8'b0000_0001, 10);
      else        show(d, 4'(d), 10);
    end
    blank(3); #2;
    check("t3_digits", 64'(digits_out), 64'h87653010);
    check("t3_err",    64'(err_mask), 64'h04);
    check("t3_dp",     64'(dp_out), 64'h04);

    // multi_err set / hold / clear / set-wins
    show_raw(0, 8'hFF, 0);
    an_in = 8'b1111_0011;
    @(negedge clk);
    blank(3); #2;
    check("t4_multi_set", 64'(multi_err), 64'd1);
    blank(5); #2;
    check("t4_multi_hold", 64'(multi_err), 64'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    blank(2); #2;
    check("t4_multi_clr", 64'(multi_err), 64'd0);
    an_in = 8'b1111_0011;
    clr_err = 1'b1;
    @(negedge clk);
    an_in = '1;
    @(negedge clk);
    clr_err = 1'b0;
    blank(2); #2;
    check("t4_set_wins", 64'(multi_err), 64'd1);

    // Stale after TIMEOUT idle cycles, dropped by the next frame
    n = 0;
    while (stale !== 1'b1 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("t5_stale_up",    64'(stale), 64'd1);
    check("t5_stale_delay", 64'(stale_rise - last_fv_cyc), 64'd50);
    for (int d = 0; d < 8; d++) show(d, 4'(d + 1), 10);
    blank(3); #2;
    check("t5_stale_at_frame", 64'(stale_at_fv), 64'd0);
    check("t5_stale_now",      64'(stale), 64'd0);
    check("t5_digits",         64'(digits_out), 64'h76544321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
